seq_mult64: RTL and testbench



---
 rtl/seq_mult64_if.sv | 24 ++
 rtl/seq_mult64.sv | 122 ++++++++++++
 tb/tb_seq_mult64.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_mult64_if.sv
// seq_mult64_if: START/DONE handshake and operand/product bus for seq_mult64.
// The master side (multicycle controller) drives start/a/b.
// The slave side (the multiplier) returns busy/done and the product words.
interface seq_mult64_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/seq_mult64.sv
// seq_mult64: iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// One multiplier bit is retired per cycle, so the latency is fixed at WIDTH cycles.
// The product is returned as registered HI/LO words that hold until the next completion.
// Optional feature macro SEQ_MULT64_SIGNED_EN: when defined, the operands are treated as
// two's complement. The magnitudes are multiplied and the product is negated at completion.
module seq_mult64 #(
    parameter int WIDTH = 64
) (
    input  logic         clk,
    input  logic         rst,
    seq_mult64_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [6:0]           cnt_q, cnt_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   product;
    logic [WIDTH-1:0]     a_op;
    logic [WIDTH-1:0]     b_op;

`ifdef SEQ_MULT64_SIGNED_EN
    logic                 neg_q, neg_d;

    // Convert the operands to magnitudes at capture; the most-negative value maps onto itself as an unsigned 2^(WIDTH-1)
    always_comb begin
        a_op = bus.a[WIDTH-1] ? -bus.a : bus.a;
        b_op = bus.b[WIDTH-1] ? -bus.b : bus.b;
    end
`else
    // Unsigned build: the operands are captured as they arrive
    always_comb begin
        a_op = bus.a;
        b_op = bus.b;
    end
`endif

    // One shift-add step: conditionally add the multiplicand into the upper half, then shift {carry, acc} right
    always_comb begin
        sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        acc_step = {sum, acc_q[WIDTH-1:1]};
`ifdef SEQ_MULT64_SIGNED_EN
        product  = neg_q ? -acc_step : acc_step;
`else
        product  = acc_step;
`endif
    end

    // Controller: capture in IDLE/FIN, iterate in RUN, retire the product after the last step
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef SEQ_MULT64_SIGNED_EN
        neg_d   = neg_q;
`endif
        case (state_q)
            IDLE, FIN: begin
                if (bus.start) begin
                    mcand_d = a_op;
                    acc_d   = {{WIDTH{1'b0}}, b_op};
                    cnt_d   = '0;
`ifdef SEQ_MULT64_SIGNED_EN
                    neg_d   = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
`endif
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == 7'(WIDTH-1)) begin
                    hi_d    = product[2*WIDTH-1:WIDTH];
                    lo_d    = product[WIDTH-1:0];
                    state_d = FIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight and clears the result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef SEQ_MULT64_SIGNED_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef SEQ_MULT64_SIGNED_EN
            neg_q   <= neg_d;
`endif
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == FIN);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_seq_mult64.sv
// tb_seq_mult64: self-checking bench for seq_mult64.
// Expected products come from a plain arithmetic model of the multiply.
// The model is signed when SEQ_MULT64_SIGNED_EN is defined and unsigned otherwise.
module tb_seq_mult64;
    logic clk;
    logic rst;
    int   checks;
    int   passes;

    seq_mult64_if #(.WIDTH(64)) bus ();

    seq_mult64 #(.WIDTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Global watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [127:0] model(input logic [63:0] x, input logic [63:0] y);
`ifdef SEQ_MULT64_SIGNED_EN
        logic signed [127:0] sx;
        logic signed [127:0] sy;
        sx = $signed(x);
        sy = $signed(y);
        return 128'(sx * sy);
`else
        return {64'd0, x} * {64'd0, y};
`endif
    endfunction

    // Present operands with START for one edge; called #1 after an edge
    task automatic issue(input logic [63:0] x, input logic [63:0] y);
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Count edges until DONE, noting any BUSY/DONE overlap or gap in BUSY before DONE
    task automatic wait_for_done(output int n, output bit bad_flags);
        n = 0;
        bad_flags = 1'b0;
        while (!bus.done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.busy && bus.done) bad_flags = 1'b1;
            if (!bus.busy && !bus.done) bad_flags = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b1;
        bus.a = 64'd12345;
        bus.b = 64'd678;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", bus.busy); else passes++;
        checks++; if (bus.done !== 1'b0) $display("[TB] FAIL reset_done got %b want 0", bus.done); else passes++;
        checks++; if (bus.hi !== 64'd0) $display("[TB] FAIL reset_hi got %h want 0", bus.hi); else passes++;
        checks++; if (bus.lo !== 64'd0) $display("[TB] FAIL reset_lo got %h want 0", bus.lo); else passes++;
        bus.start = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL post_reset_busy got %b want 0", bus.busy); else passes++;
    endtask

    task automatic test_products();
        logic [63:0] va [$];
        logic [63:0] vb [$];
        logic [127:0] exp_p;
        int n;
        bit bad;
        va = {64'd1431655700, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0,
              64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd1};
        vb = {64'd1431655701, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'd0,
              64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        for (int i = 0; i < 6; i++) begin
            va.push_back({$urandom, $urandom});
            vb.push_back({$urandom, $urandom});
        end
        for (int i = 0; i < va.size(); i++) begin
            exp_p = model(va[i], vb[i]);
            issue(va[i], vb[i]);
            checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0)
                $display("[TB] FAIL accept_flags op %0d got busy=%b done=%b want busy=1 done=0", i, bus.busy, bus.done);
            else passes++;
            wait_for_done(n, bad);
            checks++; if (n !== 64) $display("[TB] FAIL latency op %0d got %0d want 64", i, n); else passes++;
            checks++; if (bad !== 1'b0) $display("[TB] FAIL busy_done_flags op %0d got bad=%b want 0", i, bad); else passes++;
            checks++; if ({bus.hi, bus.lo} !== exp_p)
                $display("[TB] FAIL product op %0d got %h_%h want %h", i, bus.hi, bus.lo, exp_p);
            else passes++;
            @(posedge clk);
            #1;
            checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0)
                $display("[TB] FAIL done_pulse op %0d got busy=%b done=%b want 0/0", i, bus.busy, bus.done);
            else passes++;
            checks++; if ({bus.hi, bus.lo} !== exp_p)
                $display("[TB] FAIL hold op %0d got %h_%h want %h", i, bus.hi, bus.lo, exp_p);
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bit bad;
        issue(64'd7, 64'd6);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
        end
        bus.start = 1'b1;
        bus.a = 64'd2;
        bus.b = 64'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1) $display("[TB] FAIL ignored_start_busy got %b want 1", bus.busy); else passes++;
        wait_for_done(n, bad);
        checks++; if (n + 11 !== 64) $display("[TB] FAIL ignored_start_latency got %0d want 64", n + 11); else passes++;
        checks++; if ({bus.hi, bus.lo} !== model(64'd7, 64'd6))
            $display("[TB] FAIL ignored_start_product got %h_%h want %h", bus.hi, bus.lo, model(64'd7, 64'd6));
        else passes++;
        issue(64'd3, 64'd3);
        checks++; if (bus.busy !== 1'b1) $display("[TB] FAIL b2b_accept got busy=%b want 1", bus.busy); else passes++;
        wait_for_done(n, bad);
        checks++; if (n !== 64) $display("[TB] FAIL b2b_latency got %0d want 64", n); else passes++;
        checks++; if (bad !== 1'b0) $display("[TB] FAIL b2b_flags got bad=%b want 0", bad); else passes++;
        checks++; if ({bus.hi, bus.lo} !== model(64'd3, 64'd3))
            $display("[TB] FAIL b2b_product got %h_%h want %h", bus.hi, bus.lo, model(64'd3, 64'd3));
        else passes++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_abort();
        int done_seen;
        int busy_seen;
        issue(64'd7, 64'd6);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0)
            $display("[TB] FAIL abort_flags got busy=%b done=%b want 0/0", bus.busy, bus.done);
        else passes++;
        checks++; if ({bus.hi, bus.lo} !== 128'd0)
            $display("[TB] FAIL abort_result got %h_%h want 0", bus.hi, bus.lo);
        else passes++;
        done_seen = 0;
        busy_seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) done_seen++;
            if (bus.busy) busy_seen++;
        end
        checks++; if (done_seen !== 0) $display("[TB] FAIL abort_no_done got %0d want 0", done_seen); else passes++;
        checks++; if (busy_seen !== 0) $display("[TB] FAIL abort_no_busy got %0d want 0", busy_seen); else passes++;
        checks++; if ({bus.hi, bus.lo} !== 128'd0)
            $display("[TB] FAIL abort_hold got %h_%h want 0", bus.hi, bus.lo);
        else passes++;
    endtask

    // Scenario sequence
    initial begin
        clk = 1'b0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        checks = 0;
        passes = 0;
        test_reset();
        test_products();
        test_back_to_back();
        test_abort();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
